// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared definitions for the 9-bit accumulator processor
// control sequencer.
//   seq_state_t      - sequencer FSM state encoding
//   OP_*             - 4-bit opcodes, found in IrQ[8:5]
//   MEM_TIMEOUT_DEF  - default watchdog limit (cycles in MEM without an ack)
//   CNT_W_DEF        - default performance counter width
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } seq_state_t;

    localparam logic [3:0] OP_ASSIGN = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_OR     = 4'h4;
    localparam logic [3:0] OP_MOV    = 4'h5;
    localparam logic [3:0] OP_LW     = 4'h6;
    localparam logic [3:0] OP_SW     = 4'h7;
    localparam logic [3:0] OP_CLRSC  = 4'h8;
    localparam logic [3:0] OP_JMP    = 4'h9;
    localparam logic [3:0] OP_BEQ    = 4'hA;
    localparam logic [3:0] OP_BNE    = 4'hB;
    localparam logic [3:0] OP_BGE    = 4'hC;
    // 4'hD and 4'hE are unassigned and execute as NOP.
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam int MEM_TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: data memory req/ack handshake.
//   MemReq - request, held for the whole MEM state
//   MemWe  - write qualifier for MemReq (store)
//   MemAck - access complete, from the memory
// master: sequencer side; slave: data memory side.
interface instr_sequencer_if;
    logic MemReq;
    logic MemWe;
    logic MemAck;

    modport master (output MemReq, output MemWe, input MemAck);
    modport slave  (input MemReq, input MemWe, output MemAck);
endinterface

// File: rtl/instr_sequencer_seq_decode.sv
// seq_decode: combinational opcode class decode from the latched instruction.
// Ports:
//   op        in  4  opcode, IrQ[8:5]
//   sel       in  1  IrQ[4], MOV direction (0: to accumulator, 1: to reg file)
//   is_mem    out 1  LW or SW, needs the MEM state
//   is_store  out 1  SW
//   is_branch out 1  BEQ/BNE/BGE/JMP, may load the PC with a target
//   acc_wr    out 1  writes the accumulator in WB
//   rf_wr     out 1  writes the register file in WB
//   sc_en     out 1  updates the carry register in WB
//   sc_clr    out 1  clears the carry register in WB
module seq_decode
    import instr_sequencer_pkg::*;
(
    input  logic [3:0] op,
    input  logic       sel,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_branch,
    output logic       acc_wr,
    output logic       rf_wr,
    output logic       sc_en,
    output logic       sc_clr
);

    always_comb begin
        is_mem    = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        acc_wr    = 1'b0;
        rf_wr     = 1'b0;
        sc_en     = 1'b0;
        sc_clr    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                acc_wr = 1'b1;
                sc_en  = 1'b1;
            end
            OP_AND, OP_OR, OP_ASSIGN: acc_wr = 1'b1;
            OP_MOV: begin
                acc_wr = !sel;
                rf_wr  = sel;
            end
            OP_LW: begin
                is_mem = 1'b1;
                rf_wr  = 1'b1;
            end
            OP_SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_CLRSC: sc_clr = 1'b1;
            OP_JMP, OP_BEQ, OP_BNE, OP_BGE: is_branch = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer for the 9-bit accumulator
// processor. Steps each instruction through FETCH, EXEC, optional MEM and WB,
// issuing one-cycle write and PC-update strobes in WB.
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Start               level, sampled only in IDLE or HALT
//   Instruction[8:0]    ROM output at the current PC
//   AluZero, AluGe      ALU flags, sampled in EXEC for branches
//   mem                 data memory req/ack handshake (master side)
//   IrQ[8:0]            latched instruction
//   AccWe, RfWe         accumulator / register file write strobes
//   ScEn, ScClr         carry register enable / clear
//   PcInc, PcJump       PC += 1 / PC <= target
//   Done, Err           halted / halted by memory timeout
//   CycleCnt, InstrCnt  performance counters
// Optional feature: define SEQ_PERF_CNT_EN to build the saturating
// performance counters; otherwise CycleCnt/InstrCnt read as 0.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic [8:0]          Instruction,
    input  logic                AluZero,
    input  logic                AluGe,
    instr_sequencer_if.master   mem,
    output logic [8:0]          IrQ,
    output logic                AccWe,
    output logic                RfWe,
    output logic                ScEn,
    output logic                ScClr,
    output logic                PcInc,
    output logic                PcJump,
    output logic                Done,
    output logic                Err,
    output logic [CNT_W-1:0]    CycleCnt,
    output logic [CNT_W-1:0]    InstrCnt
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    seq_state_t      state;
    logic [8:0]      ir_q;
    logic            taken;
    logic            err_q;
    logic [WD_W-1:0] wd;

    logic is_mem, is_store, is_branch, acc_wr, rf_wr, sc_en, sc_clr;
    logic branch_cond;

    seq_decode u_dec (
        .op        (ir_q[8:5]),
        .sel       (ir_q[4]),
        .is_mem    (is_mem),
        .is_store  (is_store),
        .is_branch (is_branch),
        .acc_wr    (acc_wr),
        .rf_wr     (rf_wr),
        .sc_en     (sc_en),
        .sc_clr    (sc_clr)
    );

    // Condition for the branch class; JMP is unconditional.
    always_comb begin
        case (ir_q[8:5])
            OP_BEQ:  branch_cond = AluZero;
            OP_BNE:  branch_cond = !AluZero;
            OP_BGE:  branch_cond = AluGe;
            default: branch_cond = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            ir_q  <= '0;
            taken <= 1'b0;
            err_q <= 1'b0;
            wd    <= '0;
        end else begin
            case (state)
                S_IDLE: if (Start) state <= S_FETCH;
                S_FETCH: begin
                    ir_q  <= Instruction;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    taken <= is_branch && branch_cond;
                    // EXEC is the only way into MEM, so the watchdog is
                    // cleared here for every memory access.
                    wd    <= '0;
                    if (ir_q[8:5] == OP_HALT) state <= S_HALT;
                    else if (is_mem)          state <= S_MEM;
                    else                      state <= S_WB;
                end
                S_MEM: begin
                    // Ack takes priority over an expiring watchdog.
                    if (mem.MemAck) begin
                        state <= S_WB;
                    end else if (wd == WD_LAST) begin
                        err_q <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_WB: state <= S_FETCH;
                S_HALT: begin
                    if (Start) begin
                        err_q <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs: decoded from state and registers only, so a reset
    // pulls them all low without waiting for a clock.
    assign mem.MemReq = (state == S_MEM);
    assign mem.MemWe  = (state == S_MEM) && is_store;
    assign IrQ        = ir_q;
    assign AccWe      = (state == S_WB) && acc_wr;
    assign RfWe       = (state == S_WB) && rf_wr;
    assign ScEn       = (state == S_WB) && sc_en;
    assign ScClr      = (state == S_WB) && sc_clr;
    assign PcInc      = (state == S_WB) && !taken;
    assign PcJump     = (state == S_WB) && taken;
    assign Done       = (state == S_HALT);
    assign Err        = err_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt, ins_cnt;
    logic             start_acc, active;

    assign start_acc = ((state == S_IDLE) || (state == S_HALT)) && Start;
    assign active    = (state != S_IDLE) && (state != S_HALT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else if (start_acc) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            if (active && (cyc_cnt != '1))           cyc_cnt <= cyc_cnt + 1'b1;
            if ((state == S_WB) && (ins_cnt != '1)) ins_cnt <= ins_cnt + 1'b1;
        end
    end

    assign CycleCnt = cyc_cnt;
    assign InstrCnt = ins_cnt;
`else
    assign CycleCnt = '0;
    assign InstrCnt = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed bench for instr_sequencer. Inputs change and
// outputs are checked on the falling clock edge; state moves on the rising one.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int CW = 16;

    // Bit positions in the packed output vector.
    localparam logic [9:0] O_REQ  = 10'h200;
    localparam logic [9:0] O_WE   = 10'h100;
    localparam logic [9:0] O_ACC  = 10'h080;
    localparam logic [9:0] O_RF   = 10'h040;
    localparam logic [9:0] O_SCEN = 10'h020;
    localparam logic [9:0] O_SCCL = 10'h010;
    localparam logic [9:0] O_INC  = 10'h008;
    localparam logic [9:0] O_JMP  = 10'h004;
    localparam logic [9:0] O_DONE = 10'h002;
    localparam logic [9:0] O_ERR  = 10'h001;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic [8:0]    Instruction = '0;
    logic          AluZero = 1'b0;
    logic          AluGe = 1'b0;
    logic [8:0]    IrQ;
    logic          AccWe, RfWe, ScEn, ScClr, PcInc, PcJump, Done, Err;
    logic [CW-1:0] CycleCnt, InstrCnt;

    int total = 0;
    int bad   = 0;

    instr_sequencer_if mem_bus ();

    instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Instruction (Instruction),
        .AluZero     (AluZero),
        .AluGe       (AluGe),
        .mem         (mem_bus),
        .IrQ         (IrQ),
        .AccWe       (AccWe),
        .RfWe        (RfWe),
        .ScEn        (ScEn),
        .ScClr       (ScClr),
        .PcInc       (PcInc),
        .PcJump      (PcJump),
        .Done        (Done),
        .Err         (Err),
        .CycleCnt    (CycleCnt),
        .InstrCnt    (InstrCnt)
    );

    always #5 Clk = ~Clk;

    logic [9:0] outs;
    assign outs = {mem_bus.MemReq, mem_bus.MemWe, AccWe, RfWe, ScEn, ScClr,
                   PcInc, PcJump, Done, Err};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] lo);
        return {op, lo};
    endfunction

    // Entered on the falling edge of a FETCH cycle; leaves on the falling
    // edge of the following FETCH. Flags are held through EXEC.
    task automatic do_instr(input string tag, input logic [8:0] i,
                            input logic z, input logic ge, input logic [9:0] exp_wb);
        Instruction = i;
        AluZero = z;
        AluGe = ge;
        chk({tag, ".fetch"}, 32'(outs), 32'(0));
        @(negedge Clk);
        chk({tag, ".exec"}, 32'(outs), 32'(0));
        chk({tag, ".irq"}, 32'(IrQ), 32'(i));
        @(negedge Clk);
        chk({tag, ".wb"}, 32'(outs), 32'(exp_wb));
        @(negedge Clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        mem_bus.MemAck = 1'b0;

        // Reset
        @(negedge Clk);
        chk("rst.outs", 32'(outs), 32'(0));
        chk("rst.irq", 32'(IrQ), 32'(0));
        chk("rst.cyc", 32'(CycleCnt), 32'(0));
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("idle.outs", 32'(outs), 32'(0));

        // Start, then ADD (reg form)
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        do_instr("add", ins(OP_ADD, 5'b00011), 1'b0, 1'b0, O_ACC | O_SCEN | O_INC);
`ifdef SEQ_PERF_CNT_EN
        chk("add.icnt", 32'(InstrCnt), 32'(1));
        chk("add.ccnt", 32'(CycleCnt), 32'(3));
`else
        chk("add.icnt", 32'(InstrCnt), 32'(0));
        chk("add.ccnt", 32'(CycleCnt), 32'(0));
`endif

        // LW, ack on the third MEM cycle
        Instruction = ins(OP_LW, 5'b00010);
        chk("lw.fetch", 32'(outs), 32'(0));
        @(negedge Clk);
        chk("lw.exec", 32'(outs), 32'(0));
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            if (k == 3) mem_bus.MemAck = 1'b1;
            chk($sformatf("lw.mem%0d", k), 32'(outs), 32'(O_REQ));
        end
        @(negedge Clk);
        mem_bus.MemAck = 1'b0;
        chk("lw.wb", 32'(outs), 32'(O_RF | O_INC));

        // SW, no ack in MEM: a stray ack in EXEC must be ignored
        @(negedge Clk);
        Instruction = ins(OP_SW, 5'b00001);
        chk("sw.fetch", 32'(outs), 32'(0));
        @(negedge Clk);
        mem_bus.MemAck = 1'b1;
        chk("sw.exec", 32'(outs), 32'(0));
        for (int k = 1; k <= 15; k++) begin
            @(negedge Clk);
            mem_bus.MemAck = 1'b0;
            chk($sformatf("sw.mem%0d", k), 32'(outs), 32'(O_REQ | O_WE));
        end
        @(negedge Clk);
        chk("sw.halt1", 32'(outs), 32'(O_DONE | O_ERR));
        @(negedge Clk);
        chk("sw.halt2", 32'(outs), 32'(O_DONE | O_ERR));
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("restart.err", 32'(Err), 32'(0));

        // Branches and remaining classes
        do_instr("beq_t", ins(OP_BEQ, 5'h04), 1'b1, 1'b0, O_JMP);
        do_instr("beq_n", ins(OP_BEQ, 5'h04), 1'b0, 1'b1, O_INC);
        do_instr("bne_t", ins(OP_BNE, 5'h05), 1'b0, 1'b0, O_JMP);
        do_instr("bne_n", ins(OP_BNE, 5'h05), 1'b1, 1'b1, O_INC);
        do_instr("bge_t", ins(OP_BGE, 5'h06), 1'b0, 1'b1, O_JMP);
        do_instr("bge_n", ins(OP_BGE, 5'h06), 1'b1, 1'b0, O_INC);
        do_instr("jmp",   ins(OP_JMP, 5'h07), 1'b0, 1'b0, O_JMP);
        do_instr("undef", ins(4'hD,   5'h1F), 1'b1, 1'b1, O_INC);
        do_instr("mov_rf",  ins(OP_MOV, 5'b10001), 1'b0, 1'b0, O_RF | O_INC);
        do_instr("mov_acc", ins(OP_MOV, 5'b00001), 1'b0, 1'b0, O_ACC | O_INC);
        do_instr("clrsc", ins(OP_CLRSC, 5'h00), 1'b0, 1'b0, O_SCCL | O_INC);
        do_instr("sub",   ins(OP_SUB, 5'h02), 1'b0, 1'b0, O_ACC | O_SCEN | O_INC);
        do_instr("or",    ins(OP_OR,  5'h02), 1'b0, 1'b0, O_ACC | O_INC);

        // SW with ack in the last watchdog cycle: ack wins
        Instruction = ins(OP_SW, 5'b00011);
        @(negedge Clk);
        for (int k = 1; k <= 15; k++) begin
            @(negedge Clk);
            if (k == 15) mem_bus.MemAck = 1'b1;
        end
        chk("swlast.mem15", 32'(outs), 32'(O_REQ | O_WE));
        @(negedge Clk);
        mem_bus.MemAck = 1'b0;
        chk("swlast.wb", 32'(outs), 32'(O_INC));
        @(negedge Clk);

        // HALT opcode
        Instruction = ins(OP_HALT, 5'h00);
        chk("halt.fetch", 32'(outs), 32'(0));
        @(negedge Clk);
        chk("halt.exec", 32'(outs), 32'(0));
        @(negedge Clk);
        chk("halt.done", 32'(outs), 32'(O_DONE));
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("halt.refetch", 32'(outs), 32'(0));

        // Reset during the second MEM cycle of LW
        Instruction = ins(OP_LW, 5'b00100);
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        chk("rstmem.req", 32'(outs), 32'(O_REQ));
        #2 Reset_n = 1'b0;
        #1;
        chk("rstmem.outs", 32'(outs), 32'(0));
        chk("rstmem.irq", 32'(IrQ), 32'(0));
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("rstmem.idle", 32'(outs), 32'(0));
        chk("rstmem.icnt", 32'(InstrCnt), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
